// File: rtl/spi_master.sv
// SPI master, mode 0, 16-bit frames, MSB first, active-high chip select.
// Every output is registered; the FSM state is exported on state_dbg.
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs,
  output logic        busy,
  output logic        done,
  output logic [15:0] data_out,
  output logic [2:0]  state_dbg
);

  // Handshake: start is a level request sampled every clk edge; it is
  // accepted only while the FSM is in IDLE (busy=0, which includes the
  // done cycle) and otherwise ignored. done is a one-cycle pulse and
  // data_out is valid from done until the next done.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4
  } state_t;

  localparam logic [7:0] DIV    = 8'(CLK_DIV);
  localparam logic [7:0] DIV_M1 = DIV - 8'd1;

  state_t      state, state_n;
  logic [7:0]  div_cnt, div_n;
  logic [4:0]  bit_cnt, bit_n;
  logic [15:0] tx_shift, tx_n;
  logic [15:0] rx_shift, rx_n;
  logic        trail_hold, trail_n;
  logic        sclk_n, mosi_n, cs_n, busy_n, done_n;
  logic [15:0] dout_n;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= 5'd0;
      tx_shift   <= 16'h0000;
      rx_shift   <= 16'h0000;
      trail_hold <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= 16'h0000;
    end else begin
      state      <= state_n;
      div_cnt    <= div_n;
      bit_cnt    <= bit_n;
      tx_shift   <= tx_n;
      rx_shift   <= rx_n;
      trail_hold <= trail_n;
      sclk       <= sclk_n;
      mosi       <= mosi_n;
      cs         <= cs_n;
      busy       <= busy_n;
      done       <= done_n;
      data_out   <= dout_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt + 8'd1;
    bit_n   = bit_cnt;
    tx_n    = tx_shift;
    rx_n    = rx_shift;
    trail_n = trail_hold;
    sclk_n  = sclk;
    mosi_n  = mosi;
    cs_n    = cs;
    busy_n  = busy;
    done_n  = 1'b0;
    dout_n  = data_out;
    case (state)
      IDLE: begin
        div_n  = 8'd0;
        sclk_n = 1'b0;
        cs_n   = 1'b0;
        mosi_n = 1'b0;
        busy_n = 1'b0;
        if (start) begin
          state_n = LEAD;
          tx_n    = data_in;
          rx_n    = 16'h0000;
          bit_n   = 5'd0;
          trail_n = 1'b0;
          cs_n    = 1'b1;
          busy_n  = 1'b1;
          mosi_n  = data_in[15];
        end
      end
      LEAD: begin
        if (div_cnt == DIV_M1) begin
          state_n = HIGH;
          div_n   = 8'd0;
          sclk_n  = 1'b1;
          rx_n    = {rx_shift[14:0], miso};
        end
      end
      HIGH: begin
        if (div_cnt == DIV_M1) begin
          div_n  = 8'd0;
          bit_n  = bit_cnt + 5'd1;
          sclk_n = 1'b0;
          if (bit_cnt == 5'd15) begin
            state_n = TRAIL;
          end else begin
            state_n = LOW;
            tx_n    = {tx_shift[14:0], 1'b0};
            mosi_n  = tx_shift[14];
          end
        end
      end
      LOW: begin
        if (div_cnt == DIV_M1) begin
          state_n = HIGH;
          div_n   = 8'd0;
          sclk_n  = 1'b1;
          rx_n    = {rx_shift[14:0], miso};
        end
      end
      TRAIL: begin
        // Closing SCLK-low half-period, then a CS hold of CLK_DIV+1 cycles,
        // which places done 34*CLK_DIV+1 cycles after acceptance.
        if (!trail_hold) begin
          if (div_cnt == DIV_M1) begin
            trail_n = 1'b1;
            div_n   = 8'd0;
          end
        end else if (div_cnt == DIV) begin
          state_n = IDLE;
          div_n   = 8'd0;
          trail_n = 1'b0;
          cs_n    = 1'b0;
          mosi_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          dout_n  = rx_shift;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1), a
// frame-level timing model checked every cycle, and a loopback slave monitor.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, tie1, sel;
  logic [15:0] data_in;

  logic        sclk_a, mosi_a, cs_a, busy_a, done_a;
  logic [15:0] dout_a;
  logic [2:0]  st_a;
  logic        sclk_b, mosi_b, cs_b, busy_b, done_b;
  logic [15:0] dout_b;
  logic [2:0]  st_b;
  logic        miso_a, miso_b;

  assign miso_a = tie1 ? 1'b1 : mosi_a;
  assign miso_b = tie1 ? 1'b1 : mosi_b;

  spi_master #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .miso(miso_a),
    .sclk(sclk_a), .mosi(mosi_a), .cs(cs_a), .busy(busy_a), .done(done_a),
    .data_out(dout_a), .state_dbg(st_a)
  );

  spi_master #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .miso(miso_b),
    .sclk(sclk_b), .mosi(mosi_b), .cs(cs_b), .busy(busy_b), .done(done_b),
    .data_out(dout_b), .state_dbg(st_b)
  );

  logic        sclk_s, mosi_s, cs_s, busy_s, done_s;
  logic [15:0] dout_s;
  assign sclk_s = sel ? sclk_b : sclk_a;
  assign mosi_s = sel ? mosi_b : mosi_a;
  assign cs_s   = sel ? cs_b   : cs_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign dout_s = sel ? dout_b : dout_a;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int dval();
    return sel ? 1 : 2;
  endfunction

  // Frame model: one frame = CLK_DIV-cycle phases LEAD, 16 x (HIGH, LOW)
  // without the last LOW, TRAIL; done arrives 34*D+1 cycles after acceptance.
  int          cyc = 0;
  bit          f_on = 1'b0;
  int          f_t0 = 0;
  logic [15:0] f_w = 16'h0, f_rx = 16'h0, last_dout = 16'h0;

  always @(posedge clk) begin
    int  kp;
    bit  idle_before;
    kp          = cyc - f_t0;
    idle_before = !f_on || (kp >= 34 * dval() + 1);
    cyc <= cyc + 1;
    if (reset) begin
      f_on      <= 1'b0;
      last_dout <= 16'h0;
    end else if (idle_before && start) begin
      if (f_on) last_dout <= f_rx;
      f_on <= 1'b1;
      f_t0 <= cyc + 1;
      f_w  <= data_in;
      f_rx <= tie1 ? 16'hFFFF : data_in;
    end
  end

  int          done_cnt = 0, mosi_ones = 0, slave_edges = 0, edges_at_done = 0;
  logic [15:0] slave_word = 16'h0;
  logic        sclk_prev = 1'b0, mosi_prev = 1'b0;

  always @(negedge clk) begin
    int          k, d, p, b;
    logic [20:0] exp_v, act;
    d = dval();
    k = cyc - f_t0;
    if (f_on && k <= 34 * d) begin
      p = k / d;
      b = p / 2;
      if (b > 15) b = 15;
      exp_v = {((p % 2) == 1 && p <= 31), 1'b1, f_w[15 - b], 1'b1, 1'b0, last_dout};
    end else if (f_on && k == 34 * d + 1) begin
      exp_v = {5'b00001, f_rx};
    end else begin
      exp_v = {5'b00000, (f_on ? f_rx : last_dout)};
    end
    act = {sclk_s, cs_s, mosi_s, busy_s, done_s, dout_s};
    if (cyc > 0) check("cycle_outputs{sclk,cs,mosi,busy,done,dout}", {11'h0, act}, {11'h0, exp_v});

    if (sclk_s && !sclk_prev) begin
      check("mosi_stable_at_sclk_rise", {31'h0, mosi_s}, {31'h0, mosi_prev});
      slave_word  <= {slave_word[14:0], mosi_s};
      slave_edges <= slave_edges + 1;
    end
    if (done_s) begin
      check("slave_word_msb_first", {16'h0, slave_word}, {16'h0, f_w});
      done_cnt      <= done_cnt + 1;
      edges_at_done <= slave_edges;
      slave_edges   <= 0;
    end
    if (mosi_s) mosi_ones <= mosi_ones + 1;
    if (reset) begin
      slave_edges <= 0;
      slave_word  <= 16'h0;
    end
    sclk_prev <= sclk_s;
    mosi_prev <= mosi_s;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Returns at the negedge of the done cycle; n counts negedges waited.
  task automatic wait_done(input int budget, output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (done_s) ok = 1'b1;
    end
    check("done_seen", {31'h0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    int n, d0, ones0, gap;
    reset = 1'b1; start = 1'b0; data_in = 16'h0; tie1 = 1'b0; sel = 1'b0;

    // Loopback, CLK_DIV=2, A5C3
    do_reset();
    check("reset_state", {11'h0, sclk_s, cs_s, mosi_s, busy_s, done_s, dout_s}, 32'h0);
    data_in = 16'hA5C3; start = 1'b1;
    tick(1);
    start = 1'b0; data_in = 16'h0000;
    wait_done(200, n);
    check("latency_div2", n, 32'd69);
    check("dout_a5c3", {16'h0, dout_s}, 32'h0000A5C3);
    #1;
    check("sclk_rises_per_frame", edges_at_done, 32'd16);

    // CLK_DIV=1, MISO tied high, all-zero word
    sel = 1'b1; tie1 = 1'b1;
    do_reset();
    ones0 = mosi_ones;
    data_in = 16'h0000; start = 1'b1;
    tick(1);
    start = 1'b0; data_in = 16'hFFFF;
    wait_done(200, n);
    check("latency_div1", n, 32'd35);
    check("dout_ffff", {16'h0, dout_s}, 32'h0000FFFF);
    #1;
    check("mosi_never_high", mosi_ones - ones0, 32'd0);

    // START pulses mid-frame are ignored
    sel = 1'b0; tie1 = 1'b0;
    do_reset();
    d0 = done_cnt;
    data_in = 16'h3C5A; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    data_in = 16'h1234; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(29);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(200, n);
    check("dout_ignores_restart", {16'h0, dout_s}, 32'h00003C5A);
    tick(80);
    check("single_done", done_cnt - d0, 32'd1);

    // Reset mid-frame, with a simultaneous START that must lose
    do_reset();
    d0 = done_cnt;
    data_in = 16'hFFFF; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(29);
    reset = 1'b1; start = 1'b1; data_in = 16'h1111;
    tick(1);
    reset = 1'b0; start = 1'b0;
    check("abort_cs_sclk_busy", {29'h0, cs_s, sclk_s, busy_s}, 32'd0);
    check("abort_dout_zero", {16'h0, dout_s}, 32'h0);
    tick(1);
    check("reset_beats_start", {31'h0, cs_s}, 32'd0);
    tick(100);
    check("no_done_after_abort", done_cnt - d0, 32'd0);

    // START held through DONE: back-to-back frames
    do_reset();
    data_in = 16'h8001; start = 1'b1;
    wait_done(200, n);
    check("b2b_first_dout", {16'h0, dout_s}, 32'h00008001);
    check("b2b_cs_low_in_done", {31'h0, cs_s}, 32'd0);
    #1;
    data_in = 16'h7FFE;
    gap = 1;
    tick(1);
    start = 1'b0;
    if (!cs_s) gap++;
    check("b2b_cs_gap_cycles", gap, 32'd1);
    wait_done(200, n);
    check("b2b_latency", n, 32'd69);
    check("b2b_second_dout", {16'h0, dout_s}, 32'h00007FFE);
    tick(5);
    check("b2b_no_third_frame", {31'h0, busy_s}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: CLK_DIV, default 2, SCLK half-period in CLK cycles (legal range 1..255).
REQ-002 CLK  input  1  system clock; all logic on rising edge; single clock domain.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  transfer request, sampled each CLK edge.
REQ-005 DATA_IN  input  16  word to transmit, captured on START acceptance.
REQ-006 MISO  input  1  serial data from slave.
REQ-007 SCLK  output  1  serial clock, mode 0 (idle low).
REQ-008 MOSI  output  1  serial data to slave, MSB first.
REQ-009 CS  output  1  slave select, active-high, asserted for whole frame.
REQ-010 BUSY  output  1  high from cycle after acceptance until DONE cycle (exclusive).
REQ-011 DONE  output  1  one-cycle pulse, frame complete.
REQ-012 DATA_OUT  output  16  word received on MISO, valid from DONE until next DONE.

Function
REQ-013 FSM states IDLE, LEAD, HIGH, LOW, TRAIL; all outputs registered.
REQ-014 IDLE: SCLK=0, CS=0, BUSY=0; START=1 -> accept: tx_shift<=DATA_IN, bit_cnt<=0, div_cnt<=0, next LEAD.
REQ-015 LEAD: CS=1, BUSY=1, SCLK=0, MOSI=tx_shift[15]; after CLK_DIV cycles -> HIGH.
REQ-016 HIGH: SCLK=1 for CLK_DIV cycles; on the edge entering HIGH, rx_shift<={rx_shift[14:0],MISO}.
REQ-017 HIGH end: bit_cnt+1; if bit_cnt+1=16 -> TRAIL else -> LOW.
REQ-018 LOW: SCLK=0 for CLK_DIV cycles; on the edge entering LOW, tx_shift shifts left one, MOSI shows next bit; then -> HIGH.
REQ-019 TRAIL: SCLK=0, CS=1 for CLK_DIV cycles; then CS=0, DATA_OUT<=rx_shift, DONE=1 for one cycle, state IDLE.
REQ-020 Frame = exactly 16 SCLK rising edges; CS never deasserts mid-frame.
REQ-021 Latency: DONE high exactly 34*CLK_DIV+1 CLK cycles after the accepting edge.
REQ-022 START while BUSY=1 ignored; DATA_IN changes during frame have no effect.
REQ-023 DONE cycle is IDLE: START in DONE cycle accepted, next frame begins with no gap cycle.
REQ-024 div_cnt 8-bit, wraps to 0 at each phase change; bit_cnt 5-bit, never exceeds 16.
REQ-025 MOSI when CS=0 held 0.

Reset
REQ-026 RESET=1 at a rising edge forces IDLE; SCLK=0, CS=0, MOSI=0, BUSY=0, DONE=0, DATA_OUT=16'h0000, all counters/shift registers 0.
REQ-027 Reset mid-frame aborts: no DONE, DATA_OUT=0, CS low from next cycle.
REQ-028 RESET has priority over START in the same cycle.

Verification
REQ-029 CLK_DIV=2, MISO looped to MOSI, START with DATA_IN=16'hA5C3 -> 16 SCLK pulses, DONE at cycle 69, DATA_OUT=16'hA5C3.
REQ-030 CLK_DIV=1, MISO tied 1, DATA_IN=16'h0000 -> MOSI always 0, DONE at cycle 35, DATA_OUT=16'hFFFF.
REQ-031 START pulsed at cycles 10 and 40 of a frame with DATA_IN=16'h1234 -> ignored, single DONE, MOSI carries original word.
REQ-032 RESET at cycle 30 of a CLK_DIV=2 frame -> next cycle CS=0, SCLK=0, BUSY=0; no DONE ever issued for that frame.
REQ-033 START held high through DONE with DATA_IN=16'h8001 then 16'h7FFE (loopback) -> two contiguous frames, DATA_OUT 16'h8001 then 16'h7FFE, CS low exactly one cycle between them.
REQ-034 Loopback slave model checks MOSI stable across every SCLK rising edge and bit order MSB first.
